lpc_reg_arbiter: RTL

//  Shares the single LPC register-bank access port (Addr/Wr/Rd/DataWrSW) between two requesters:
//  the LPC host cycle engine (req 0) and the BMC-side mailbox (req 1).
//  It runs one access at a time with a req/ack handshake and returns read data muxed from the bank outputs.
//  It guarantees Rd is a single-cycle pulse, so read-clear registers (e.g. 0x0B) clear exactly once per read.

---
 rtl/lpc_arb_pkg.sv | 19 +
 rtl/lpc_arb_rr_picker.sv | 39 +++
 rtl/lpc_reg_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/lpc_arb_pkg.sv
// Package: lpc_arb_pkg
// Shared types and constants for lpc_reg_arbiter and its requester picker.
package lpc_arb_pkg;

  // Arbiter access sequence: wait for a request, drive the bank, acknowledge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

  // Requester indices; also the bit positions in the packed request vector.
  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_BMC  = 1'b1;

  // Read data returned when the address is outside the implemented bank.
  localparam logic [7:0] ERR_DATA_DEF = 8'hFF;

endpackage

// File: rtl/lpc_arb_rr_picker.sv
// Module: lpc_arb_rr_picker
// Two-way requester pick for lpc_reg_arbiter.
// Default build: round-robin, a tie goes to the requester not granted last.
// With LPC_ARB_HOST_PRIO_EN defined: fixed priority, the host always wins a tie.
module lpc_arb_rr_picker
  import lpc_arb_pkg::*;
(
  input  logic [1:0] i_req,       // bit 0 = host, bit 1 = bmc
  input  logic       i_last_gnt,  // requester granted most recently
  output logic       o_grant      // winner index; only meaningful when any i_req bit is set
);

`ifdef LPC_ARB_HOST_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_last_gnt;

  // Fixed priority: the bmc only wins when the host is not requesting.
  always_comb begin
    if (i_req[REQ_HOST]) begin
      o_grant = REQ_HOST;
    end else if (i_req[REQ_BMC]) begin
      o_grant = REQ_BMC;
    end else begin
      o_grant = REQ_HOST;
    end
  end
`else
  // Round-robin: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    case (i_req)
      2'b01:   o_grant = REQ_HOST;
      2'b10:   o_grant = REQ_BMC;
      2'b11:   o_grant = ~i_last_gnt;
      default: o_grant = REQ_HOST;
    endcase
  end
`endif

endmodule

// File: rtl/lpc_reg_arbiter.sv
// Module: lpc_reg_arbiter
// Shares the LPC register-bank access port between the LPC host cycle engine
// (requester 0) and the BMC mailbox (requester 1). One access at a time runs
// through IDLE -> ISSUE -> ACK; Wr/Rd are single-cycle strobes so read-clear
// registers clear exactly once per read.
// Optional build macro: LPC_ARB_HOST_PRIO_EN (fixed host priority instead of
// round-robin; ports and latency unchanged).
module lpc_reg_arbiter
  import lpc_arb_pkg::*;
#(
  parameter int                NUM_REG  = 32,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic                      LpcClock,
  input  logic                      PciReset,
  input  logic                      HostReq,
  input  logic                      HostWr,
  input  logic [7:0]                HostAddr,
  input  logic [DATA_W-1:0]         HostData,
  output logic                      HostAck,
  output logic [DATA_W-1:0]         HostRdData,
  output logic                      HostErr,
  input  logic                      BmcReq,
  input  logic                      BmcWr,
  input  logic [7:0]                BmcAddr,
  input  logic [DATA_W-1:0]         BmcData,
  output logic                      BmcAck,
  output logic [DATA_W-1:0]         BmcRdData,
  output logic                      BmcErr,
  output logic [7:0]                Addr,
  output logic                      Wr,
  output logic                      Rd,
  output logic [DATA_W-1:0]         DataWrSW,
  input  logic [NUM_REG*DATA_W-1:0] DataReg,
  output logic                      Busy
);

  localparam int         IDX_W     = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam logic [8:0] NUM_REG_L = 9'(NUM_REG);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_gnt;       // requester of the access in flight; also the last grant
  logic              r_lat_wr;    // latched direction; Addr/DataWrSW double as the address/data latch

  logic              w_grant;
  logic              w_load;
  logic              w_sel_wr;
  logic [7:0]        w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_in_range;
  logic              w_cur_in_range;

  logic              w_wr_nxt;
  logic              w_rd_nxt;
  logic              w_host_ack_nxt;
  logic              w_bmc_ack_nxt;
  logic              w_err_nxt;
  logic [DATA_W-1:0] w_rd_data_nxt;

  logic [DATA_W-1:0] w_regs [NUM_REG];

  genvar g;
  for (g = 0; g < NUM_REG; g++) begin : g_regs
    assign w_regs[g] = DataReg[g*DATA_W +: DATA_W];
  end

  lpc_arb_rr_picker u_picker (
    .i_req      ({BmcReq, HostReq}),
    .i_last_gnt (r_gnt),
    .o_grant    (w_grant)
  );

  assign w_load         = (r_state == IDLE) && (HostReq || BmcReq);
  assign w_sel_wr       = (w_grant == REQ_BMC) ? BmcWr   : HostWr;
  assign w_sel_addr     = (w_grant == REQ_BMC) ? BmcAddr : HostAddr;
  assign w_sel_data     = (w_grant == REQ_BMC) ? BmcData : HostData;
  assign w_sel_in_range = ({1'b0, w_sel_addr} < NUM_REG_L);
  assign w_cur_in_range = ({1'b0, Addr} < NUM_REG_L);

  // State register; reset abandons any access in flight.
  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: grant from IDLE, then exactly one ISSUE and one ACK cycle.
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = w_load ? ISSUE : IDLE;
      ISSUE:   w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output next-values: strobes are set up on the grant edge so they appear in
  // ISSUE; acks and read data are set up during ISSUE so they appear in ACK.
  always_comb begin
    w_wr_nxt       = 1'b0;
    w_rd_nxt       = 1'b0;
    w_host_ack_nxt = 1'b0;
    w_bmc_ack_nxt  = 1'b0;
    w_err_nxt      = 1'b0;
    w_rd_data_nxt  = '0;
    case (r_state)
      IDLE: begin
        w_wr_nxt = w_load &  w_sel_wr & w_sel_in_range;
        w_rd_nxt = w_load & ~w_sel_wr & w_sel_in_range;
      end
      ISSUE: begin
        w_host_ack_nxt = (r_gnt == REQ_HOST);
        w_bmc_ack_nxt  = (r_gnt == REQ_BMC);
        w_err_nxt      = ~w_cur_in_range;
        // Bank output sampled here is the pre-clear value of read-clear registers.
        if (!w_cur_in_range) begin
          w_rd_data_nxt = ERR_DATA;
        end else if (r_lat_wr) begin
          w_rd_data_nxt = DataWrSW;
        end else begin
          w_rd_data_nxt = w_regs[Addr[IDX_W-1:0]];
        end
      end
      ACK: begin
        w_err_nxt = 1'b0;
      end
      default: begin
        w_err_nxt = 1'b0;
      end
    endcase
  end

  // Grant latch: capture the winner's fields; Addr/DataWrSW hold between accesses.
  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      Addr     <= 8'h00;
      DataWrSW <= '0;
      r_lat_wr <= 1'b0;
      r_gnt    <= REQ_BMC;  // so the host wins the first tie
    end else if (w_load) begin
      Addr     <= w_sel_addr;
      DataWrSW <= w_sel_data;
      r_lat_wr <= w_sel_wr;
      r_gnt    <= w_grant;
    end
  end

  // Registered strobes, acks, errors and held read data.
  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      Wr         <= 1'b0;
      Rd         <= 1'b0;
      HostAck    <= 1'b0;
      BmcAck     <= 1'b0;
      HostErr    <= 1'b0;
      BmcErr     <= 1'b0;
      HostRdData <= '0;
      BmcRdData  <= '0;
      Busy       <= 1'b0;
    end else begin
      Wr      <= w_wr_nxt;
      Rd      <= w_rd_nxt;
      HostAck <= w_host_ack_nxt;
      BmcAck  <= w_bmc_ack_nxt;
      Busy    <= (w_state_nxt != IDLE);
      HostErr <= w_host_ack_nxt & w_err_nxt;
      BmcErr  <= w_bmc_ack_nxt & w_err_nxt;
      if (w_host_ack_nxt) begin
        HostRdData <= w_rd_data_nxt;
      end
      if (w_bmc_ack_nxt) begin
        BmcRdData <= w_rd_data_nxt;
      end
    end
  end

endmodule
